// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bundle: redirect/interrupt controls, instruction-memory port and the ID-side valid/ready head.
// master = fetch consumer side (ID/CP0/imem), slave = if_fetch_queue.
interface if_fetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          req;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          keep_slot;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic          out_bd;
    logic [4:0]    out_exc;
    logic [CW-1:0] count;

    modport master (
        output req, redirect, redirect_pc, keep_slot, imem_rdata, out_ready,
        input  imem_addr, out_valid, out_pc, out_instr, out_bd, out_exc, count
    );

    modport slave (
        input  req, redirect, redirect_pc, keep_slot, imem_rdata, out_ready,
        output imem_addr, out_valid, out_pc, out_instr, out_bd, out_exc, count
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Prefetch FIFO between PC generation and decode, with delay-slot-aware redirects,
// eret redirects, interrupt redirects and address-error tagging of fetched entries.
module if_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180,
    parameter logic [31:0] PC_LO    = 32'h0000_3000,
    parameter logic [31:0] PC_HI    = 32'h0000_6ffc
) (
    input  logic             clk,
    input  logic             rst,
    if_fetch_queue_if.slave  bus
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned CW       = AW + 1;
    localparam logic [4:0]  EXC_ADEL = 5'd4;

    typedef enum logic {RUN, SLOT} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        bd;
        logic [4:0]  exc;
    } entry_t;

    entry_t        mem [DEPTH];
    state_t        state, state_nxt;
    logic [31:0]   fetch_pc, fetch_pc_nxt;
    logic [31:0]   target, target_nxt;
    logic          last_br, last_br_nxt;
    logic [AW-1:0] rd_ptr, rd_ptr_nxt;
    logic [AW-1:0] wr_ptr, wr_ptr_nxt;
    logic [CW-1:0] count, count_nxt;

    entry_t        head;
    entry_t        fetch_entry;
    logic          addr_err;
    logic          is_br;
    logic          out_valid_c;
    logic          pop;
    logic          push;

    // Build the candidate entry for the current fetch address
    always_comb begin
        addr_err          = (fetch_pc[1:0] != 2'b00) || (fetch_pc < PC_LO) || (fetch_pc > PC_HI);
        fetch_entry.pc    = fetch_pc;
        fetch_entry.instr = addr_err ? 32'd0 : bus.imem_rdata;
        fetch_entry.bd    = (state == SLOT) || last_br;
        fetch_entry.exc   = addr_err ? EXC_ADEL : 5'd0;
        unique case (fetch_entry.instr[31:26])
            6'b000100, 6'b000101, 6'b000011: is_br = 1'b1;
            6'b000000:                       is_br = (fetch_entry.instr[5:0] == 6'b001000);
            default:                         is_br = 1'b0;
        endcase
    end

    // Head presentation; an eret redirect hides the head for its cycle
    assign head        = mem[rd_ptr];
    assign out_valid_c = (count != CW'(0)) && !(bus.redirect && !bus.keep_slot && !bus.req);
    assign pop         = out_valid_c && bus.out_ready;

    assign bus.out_valid = out_valid_c;
    assign bus.out_pc    = out_valid_c ? head.pc    : 32'd0;
    assign bus.out_instr = out_valid_c ? head.instr : 32'd0;
    assign bus.out_bd    = out_valid_c ? head.bd    : 1'b0;
    assign bus.out_exc   = out_valid_c ? head.exc   : 5'd0;
    assign bus.imem_addr = fetch_pc;
    assign bus.count     = count;

    // Next-state: req > redirect > normal push/pop
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        target_nxt   = target;
        last_br_nxt  = last_br;
        rd_ptr_nxt   = rd_ptr;
        wr_ptr_nxt   = wr_ptr;
        count_nxt    = count;
        push         = 1'b0;

        if (bus.req) begin
            rd_ptr_nxt   = '0;
            wr_ptr_nxt   = '0;
            count_nxt    = '0;
            fetch_pc_nxt = EXC_PC;
            state_nxt    = RUN;
            last_br_nxt  = 1'b0;
        end else if (bus.redirect) begin
            if (state == SLOT) begin
                target_nxt = bus.redirect_pc;
            end else if (!bus.keep_slot || pop) begin
                rd_ptr_nxt   = '0;
                wr_ptr_nxt   = '0;
                count_nxt    = '0;
                fetch_pc_nxt = bus.redirect_pc;
                last_br_nxt  = 1'b0;
            end else if (count != CW'(0)) begin
                // Delay slot is the head and stays queued
                wr_ptr_nxt   = rd_ptr + AW'(1);
                count_nxt    = CW'(1);
                fetch_pc_nxt = bus.redirect_pc;
                last_br_nxt  = 1'b0;
            end else begin
                target_nxt = bus.redirect_pc;
                state_nxt  = SLOT;
            end
        end else begin
            push = (count < CW'(DEPTH)) || pop;
            if (pop) begin
                rd_ptr_nxt = rd_ptr + AW'(1);
            end
            if (push) begin
                wr_ptr_nxt = wr_ptr + AW'(1);
                if (state == SLOT) begin
                    fetch_pc_nxt = target;
                    last_br_nxt  = 1'b0;
                    state_nxt    = RUN;
                end else begin
                    fetch_pc_nxt = fetch_pc + 32'd4;
                    last_br_nxt  = is_br && (fetch_entry.exc == 5'd0);
                end
            end
            count_nxt = count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            target   <= 32'd0;
            last_br  <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            target   <= target_nxt;
            last_br  <= last_br_nxt;
            rd_ptr   <= rd_ptr_nxt;
            wr_ptr   <= wr_ptr_nxt;
            count    <= count_nxt;
        end
    end

    // Entry storage needs no reset; occupancy gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= fetch_entry;
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed and random stimulus for if_fetch_queue, checked each cycle against a queue-based reference model.
module tb_if_fetch_queue;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h3000;
    localparam logic [31:0] EXC_PC   = 32'h4180;
    localparam logic [31:0] PC_LO    = 32'h3000;
    localparam logic [31:0] PC_HI    = 32'h6ffc;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        bd;
        logic [4:0]  exc;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_fetch_queue_if #(.DEPTH(DEPTH)) bus ();
    if_fetch_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int          errors = 0;
    int          checks = 0;
    logic [31:0] prog [logic [31:0]];
    bit          rnd_mode = 0;

    ent_t        q [$];
    logic [31:0] m_pc;
    logic [31:0] m_target;
    bit          m_lb;
    bit          m_slot;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        logic [31:0] w;
        if (prog.exists(a)) return prog[a];
        if (!rnd_mode) return {6'b001101, 5'd0, 5'd1, a[15:0]};
        w = a * 32'h9E37_79B1;
        w = w ^ (w >> 15);
        case (w[31:29])
            3'd0:    return {6'b000100, w[25:0]};
            3'd1:    return {6'b000101, w[25:0]};
            3'd2:    return {6'b000011, w[25:0]};
            3'd3:    return {6'b000000, w[25:6], 6'b001000};
            3'd4:    return {6'b000000, w[25:6], 6'b100001};
            default: return {6'b001101, w[25:0]};
        endcase
    endfunction

    function automatic bit is_branch(input logic [31:0] w);
        if (w[31:26] == 6'b000100 || w[31:26] == 6'b000101 || w[31:26] == 6'b000011) return 1'b1;
        return (w[31:26] == 6'b000000) && (w[5:0] == 6'b001000);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc     = RESET_PC;
        m_target = 32'd0;
        m_lb     = 1'b0;
        m_slot   = 1'b0;
    endtask

    // One clock cycle: drive, check combinational view, advance model, clock
    task automatic step(input bit r, input bit rd, input logic [31:0] rpc, input bit ks, input bit rdy);
        bit   exp_valid;
        bit   pop;
        bit   err;
        ent_t h;
        ent_t e;
        bus.req         = r;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.keep_slot   = ks;
        bus.out_ready   = rdy;
        bus.imem_rdata  = imem_word(bus.imem_addr);
        #1;
        exp_valid = (q.size() != 0) && !(rd && !ks && !r);
        h = exp_valid ? q[0] : '0;
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("count", 32'(bus.count), 32'(q.size()));
        chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        chk("out_pc", bus.out_pc, h.pc);
        chk("out_instr", bus.out_instr, h.instr);
        chk("out_bd", 32'(bus.out_bd), 32'(h.bd));
        chk("out_exc", 32'(bus.out_exc), 32'(h.exc));

        pop = exp_valid && rdy;
        if (r) begin
            q.delete();
            m_pc   = EXC_PC;
            m_slot = 1'b0;
            m_lb   = 1'b0;
        end else if (rd) begin
            if (m_slot) begin
                m_target = rpc;
            end else if (!ks || pop || q.size() == 0) begin
                if (ks && !pop) begin
                    m_slot   = 1'b1;
                    m_target = rpc;
                end else begin
                    q.delete();
                    m_pc = rpc;
                    m_lb = 1'b0;
                end
            end else begin
                while (q.size() > 1) void'(q.pop_back());
                m_pc = rpc;
                m_lb = 1'b0;
            end
        end else begin
            if (pop) void'(q.pop_front());
            if (q.size() < DEPTH) begin
                err     = (m_pc[1:0] != 2'b00) || (m_pc < PC_LO) || (m_pc > PC_HI);
                e.pc    = m_pc;
                e.instr = err ? 32'd0 : imem_word(m_pc);
                e.bd    = m_slot | m_lb;
                e.exc   = err ? 5'd4 : 5'd0;
                q.push_back(e);
                if (m_slot) begin
                    m_pc   = m_target;
                    m_lb   = 1'b0;
                    m_slot = 1'b0;
                end else begin
                    m_pc = m_pc + 32'd4;
                    m_lb = !err && is_branch(e.instr);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, 32'd0, 1'b0, rdy);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_addr", bus.imem_addr, RESET_PC);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_pc", bus.out_pc, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        bit          r;
        bit          rd;
        bit          ks;
        bit          rdy;
        logic [31:0] rpc;

        rst             = 1'b0;
        bus.req         = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        bus.keep_slot   = 1'b0;
        bus.out_ready   = 1'b0;
        bus.imem_rdata  = 32'd0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Streaming with ID always ready
        repeat (6) idle(1'b1);

        // Backpressure saturates the queue, then drains with concurrent push/pop
        do_reset();
        repeat (6) idle(1'b0);
        chk("sat_count", 32'(bus.count), 32'd4);
        chk("sat_addr", bus.imem_addr, 32'h3010);
        repeat (6) idle(1'b1);
        chk("drain_count", 32'(bus.count), 32'd4);

        // beq at 3000, redirect while its slot is the head
        do_reset();
        prog[32'h3000] = 32'h1000_0004;
        idle(1'b0);
        idle(1'b1);
        step(1'b0, 1'b1, 32'h3100, 1'b1, 1'b0);
        chk("keep_count", 32'(bus.count), 32'd1);
        chk("keep_pc", bus.out_pc, 32'h3004);
        chk("keep_bd", 32'(bus.out_bd), 32'd1);
        chk("keep_addr", bus.imem_addr, 32'h3100);
        repeat (4) idle(1'b1);
        prog.delete();

        // Redirect while empty: slot fetched first, then target
        do_reset();
        idle(1'b1);
        idle(1'b1);
        step(1'b0, 1'b1, 32'h3008, 1'b0, 1'b1);
        step(1'b0, 1'b1, 32'h3400, 1'b1, 1'b1);
        idle(1'b0);
        chk("slot_pc", bus.out_pc, 32'h3008);
        chk("slot_bd", 32'(bus.out_bd), 32'd1);
        chk("slot_addr", bus.imem_addr, 32'h3400);
        repeat (3) idle(1'b1);

        // eret with three entries queued
        do_reset();
        repeat (3) idle(1'b0);
        chk("eret_pre_count", 32'(bus.count), 32'd3);
        step(1'b0, 1'b1, 32'h3050, 1'b0, 1'b1);
        chk("eret_count", 32'(bus.count), 32'd0);
        idle(1'b0);
        chk("eret_head", bus.out_pc, 32'h3050);

        // req overrides SLOT; misaligned-low fetch raises AdEL
        do_reset();
        idle(1'b1);
        step(1'b0, 1'b1, 32'h2ffc, 1'b0, 1'b1);
        step(1'b0, 1'b1, 32'h3200, 1'b1, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        idle(1'b0);
        chk("req_head", bus.out_pc, 32'h4180);
        step(1'b0, 1'b1, 32'h2ffc, 1'b0, 1'b0);
        idle(1'b0);
        chk("adel_exc", 32'(bus.out_exc), 32'd4);
        chk("adel_instr", bus.out_instr, 32'd0);
        chk("adel_pc", bus.out_pc, 32'h2ffc);

        // Reset while in SLOT discards the pending target
        do_reset();
        step(1'b0, 1'b1, 32'h3020, 1'b0, 1'b1);
        step(1'b0, 1'b1, 32'h3300, 1'b1, 1'b1);
        do_reset();
        repeat (3) idle(1'b1);

        // Random traffic with program containing branches
        rnd_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            r   = ($urandom_range(0, 99) < 3);
            rd  = ($urandom_range(0, 99) < 10);
            ks  = $urandom_range(0, 1) == 1;
            rdy = ($urandom_range(0, 99) < 70);
            case ($urandom_range(0, 7))
                0:       rpc = 32'h3000 + 32'($urandom_range(0, 3)) * 32'h1 + 32'h4 * 32'($urandom_range(0, 16));
                1:       rpc = 32'h2ff0 + 32'h4 * 32'($urandom_range(0, 3));
                2:       rpc = 32'h6ff0 + 32'h4 * 32'($urandom_range(0, 7));
                default: rpc = 32'h3000 + 32'h4 * 32'($urandom_range(0, 32'h0fff));
            endcase
            step(r, rd, rpc, ks, rdy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised successor to the single-register fetch stage.
- Decouples PC generation from decode with a DEPTH-entry prefetch FIFO, driven by a valid/ready handshake toward ID.
- Handles branch/jump redirects with delay-slot preservation, eret redirects without a delay slot, and interrupt redirects to the exception vector.
- Tags each entry with branch-delay (BD) and address-error exception information for the CP0 path.

Parameters:
DEPTH, 4, FIFO entries; power of two, >=2
RESET_PC, 32'h3000, fetch address after reset
EXC_PC, 32'h4180, fetch address on interrupt
PC_LO, 32'h3000, lowest legal fetch address
PC_HI, 32'h6ffc, highest legal fetch address

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
req  in  1  interrupt/exception redirect
redirect  in  1  control-transfer redirect from ID
redirect_pc  in  32  redirect target
keep_slot  in  1  1 = branch/jump (delay slot kept), 0 = eret (no slot)
imem_addr  out  32  instruction memory address (= fetch_pc)
imem_rdata  in  32  instruction at imem_addr, combinational same cycle
out_valid  out  1  FIFO head valid
out_ready  in  1  ID accepts head (= !stall)
out_pc  out  32  head PC
out_instr  out  32  head instruction
out_bd  out  1  head lies in a delay slot
out_exc  out  5  head ExcCode: 4 = AdEL, else 0
count  out  clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst=0, asynchronous): fetch_pc=RESET_PC, count=0, state RUN, last_br=0. While empty, all out_* are 0, so a bubble presents as a NOP.
- Pop: out_valid && out_ready. Outputs are combinational from the head entry.
- Push (RUN, no req or redirect this cycle):
  - Allowed when count<DEPTH, or when count==DEPTH and a pop occurs the same cycle.
  - The entry is {fetch_pc, instr, bd=last_br, exc}; then fetch_pc += 4.
- Address error: if fetch_pc[1:0]!=0, fetch_pc<PC_LO, or fetch_pc>PC_HI, then exc=4 and instr=0; imem_rdata is ignored.
- last_br is updated on every push:
  - 1 if the pushed instr is beq (000100), bne (000101), jal (000011), or jr (opcode 0, func 001000); otherwise 0.
  - A pushed entry with exc!=0 sets last_br=0.
- Priority per cycle: req > redirect > normal push/pop.
- req:
  - Flush all entries (a same-cycle pop is still honoured).
  - fetch_pc<=EXC_PC, state<=RUN, last_br<=0. No push this cycle.
- redirect with keep_slot=1 (branch already in ID; the delay slot is the FIFO head):
  - Pop this cycle: the slot was consumed. Flush the remainder, fetch_pc<=redirect_pc, last_br<=0.
  - No pop, count>=1: keep only the head, flush the rest, fetch_pc<=redirect_pc, last_br<=0.
  - count==0: the slot is not yet fetched. Save target<=redirect_pc, state<=SLOT, fetch_pc unchanged.
- SLOT state:
  - Push one entry normally, with bd forced to 1.
  - On that push: fetch_pc<=target, last_br<=0, state<=RUN.
  - A redirect arriving in SLOT only overwrites target.
  - req overrides SLOT.
- redirect with keep_slot=0 (eret):
  - out_valid is forced 0 this cycle, so no pop.
  - Flush all, fetch_pc<=redirect_pc, last_br<=0. No push this cycle.
- No push occurs in any cycle where req or redirect is high. count then updates by pop and flush only.
- Pointer wrap: read/write pointers are clog2(DEPTH) bits wide and wrap modulo DEPTH. Full/empty are derived from count.
- Reset mid-operation: immediate return to the reset state; any pending SLOT target is discarded.

Test Plan:
- Reset release, out_ready=1, imem returns ori words → out_pc=3000,3004,3008… one per cycle, out_bd=0, out_exc=0.
- out_ready=0 for 6 cycles with DEPTH=4 → count saturates at 4, fetch_pc=3010 and stays there. Assert out_ready → pop and push in the same cycle, count stays 4 until the stream drains.
- beq pushed at 3000, then redirect (keep_slot=1, target 3100) asserted with head=3004, no pop → FIFO holds only 3004 with bd=1; next entries are 3100, 3104 with bd=0.
- Redirect keep_slot=1 while empty (fetch_pc=3008) → next push 3008 with bd=1, then 3400 (target).
- eret redirect to 3050 with 3 entries queued → out_valid=0 that cycle, count→0, next head pc=3050.
- req during SLOT, with fetch_pc set to 2ffc before the redirect → next head pc=4180. Separately, a fetch at 2ffc yields out_exc=4 and out_instr=0.
